// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between two one-entry writeback buffers.
// Write lands one edge after the handshake; a full buffer that is not granted holds its ready low.
module regfile_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req0_valid,
    input  logic [ADDR_W-1:0]        req0_addr,
    input  logic [DATA_W-1:0]        req0_data,
    output logic                     req0_ready,
    input  logic                     req1_valid,
    input  logic [ADDR_W-1:0]        req1_addr,
    input  logic [DATA_W-1:0]        req1_data,
    output logic                     req1_ready,
    output logic                     rf_write,
    output logic [ADDR_W-1:0]        rf_addr,
    output logic [DATA_W-1:0]        rf_data,
    output logic [(1<<ADDR_W)-1:0]   pending_mask,
    output logic [1:0]               grant
);

    logic              r_full0;
    logic              r_full1;
    logic [ADDR_W-1:0] r_addr0;
    logic [ADDR_W-1:0] r_addr1;
    logic [DATA_W-1:0] r_data0;
    logic [DATA_W-1:0] r_data1;
    logic              r_prio;

    logic [1:0]        w_grant;
    logic              w_load0;
    logic              w_load1;

    always_comb begin
        w_grant = 2'b00;
        if (r_full0 && r_full1) begin
            w_grant = r_prio ? 2'b10 : 2'b01;
        end else if (r_full0) begin
            w_grant = 2'b01;
        end else if (r_full1) begin
            w_grant = 2'b10;
        end
    end

    assign grant      = w_grant;
    assign req0_ready = ~r_full0 | w_grant[0];
    assign req1_ready = ~r_full1 | w_grant[1];

    // Register 0 handshakes complete but never occupy a buffer.
    assign w_load0 = req0_valid & req0_ready & (req0_addr != '0);
    assign w_load1 = req1_valid & req1_ready & (req1_addr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full0 <= 1'b0;
            r_full1 <= 1'b0;
            r_addr0 <= '0;
            r_addr1 <= '0;
            r_data0 <= '0;
            r_data1 <= '0;
            r_prio  <= 1'b0;
        end else begin
            if (w_load0) begin
                r_full0 <= 1'b1;
                r_addr0 <= req0_addr;
                r_data0 <= req0_data;
            end else if (w_grant[0]) begin
                r_full0 <= 1'b0;
            end
            if (w_load1) begin
                r_full1 <= 1'b1;
                r_addr1 <= req1_addr;
                r_data1 <= req1_data;
            end else if (w_grant[1]) begin
                r_full1 <= 1'b0;
            end
            if (w_grant[0]) begin
                r_prio <= 1'b1;
            end else if (w_grant[1]) begin
                r_prio <= 1'b0;
            end
        end
    end

    always_comb begin
        rf_write = |w_grant;
        rf_addr  = '0;
        rf_data  = '0;
        if (w_grant[0]) begin
            rf_addr = r_addr0;
            rf_data = r_data0;
        end else if (w_grant[1]) begin
            rf_addr = r_addr1;
            rf_data = r_data1;
        end
    end

    always_comb begin
        pending_mask = '0;
        if (r_full0) begin
            pending_mask[r_addr0] = 1'b1;
        end
        if (r_full1) begin
            pending_mask[r_addr1] = 1'b1;
        end
        pending_mask[0] = 1'b0;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port between two writeback requesters: requester 0 is the main pipeline writeback, requester 1 is the multicycle/memory unit. Each requester has a one-entry holding buffer with a valid/ready handshake. Grants rotate round-robin, one register write per cycle, and writes to register 0 are discarded. The block sits between the writeback sources and the register file's A3/WD/Reg_write inputs, and exports a pending-write bitmap for hazard detection in decode.

## Interface
Parameters:
- DATA_W, 32, data width of a register write.
- ADDR_W, 5, register address width; the block covers 2**ADDR_W registers.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 presents a write.
- req0_addr  in  ADDR_W  requester 0 destination register.
- req0_data  in  DATA_W  requester 0 write data.
- req0_ready  out  1  requester 0 write accepted at this posedge if valid.
- req1_valid, req1_addr, req1_data, req1_ready: same as requester 0, for requester 1.
- rf_write  out  1  write enable to the register file.
- rf_addr  out  ADDR_W  register file write address (A3).
- rf_data  out  DATA_W  register file write data (WD).
- pending_mask  out  2**ADDR_W  bit i set while any buffered, unwritten write targets register i.
- grant  out  2  one-hot: which buffer is driving the write port this cycle; 00 when idle.

## Operation
- State:
  - per requester: buf_full, buf_addr, buf_data;
  - prio, 1 bit, the requester favoured on conflict.
- Acceptance: a handshake completes when reqN_valid & reqN_ready at a posedge.
  - Normally buf_full is set and the address and data are loaded.
  - If reqN_addr == 0, the handshake still completes but the buffer is not loaded (write dropped).
- reqN_ready = ~buf_full | grant[N]. It never depends on reqN_valid, so there is no combinational valid->ready path.
- Arbitration, combinational, from buffer state only:
  - exactly one buffer full: grant it;
  - both full: grant buffer `prio`;
  - neither full: grant = 00.
- After any grant to requester N, prio <= ~N at the posedge. prio is unchanged when idle.
- Write port:
  - rf_write = |grant;
  - rf_addr/rf_data are muxed from the granted buffer;
  - when idle, rf_addr = 0 and rf_data = 0.
- Drain: a granted buffer clears at the posedge unless the same requester is refilled in that cycle (new handshake). Refill wins, giving one write per cycle per requester.
- Same address in both buffers: both writes are performed, in grant order. The register file ends with the later-granted data. pending_mask bit stays set until both buffers have drained.
- pending_mask[i] = (buf0_full & buf0_addr==i) | (buf1_full & buf1_addr==i). Bit 0 is always 0.

## Timing
- Reset values: all buffers empty, prio = 0, rf_write = 0, rf_addr = 0, rf_data = 0, grant = 00, pending_mask = 0, req0_ready = 1, req1_ready = 1.
- Reset asserted mid-operation: buffered writes are lost and no rf_write is issued. This holds even in the cycle rst rises, because outputs are combinational from buffer state that is cleared asynchronously.
- Latency:
  - handshake at edge N;
  - rf_write is high during cycle N..N+1 if granted, and the register file captures at edge N+1.
- Uncontended throughput: one write per cycle per requester.
- Contended throughput: alternating grants. Maximum wait for a full buffer is one cycle.
- Requester stall: a requester whose buffer is full and not granted sees ready = 0 and must hold valid/addr/data stable.
- Addr-0 handshake: consumes no cycle on the write port, and pending_mask is unaffected.

## Test plan
- Reset then idle:
  - after rst pulse, outputs match the reset values;
  - rst asserted with both buffers full -> rf_write drops immediately and no write lands.
- Single requester streaming:
  - req0 writes r1=0x11, r2=0x22, r3=0x33 on consecutive edges;
  - -> rf_write high for 3 consecutive cycles with addresses 1, 2, 3; req0_ready stays 1.
- Simultaneous conflict:
  - both valid on the same edge, req0 r5=0xA, req1 r6=0xB, prio=0;
  - -> cycle 1: grant=01, writes r5, req1_ready=0;
  - -> cycle 2: grant=10, writes r6; prio ends 0.
- Same address:
  - req0 r7=0x1 and req1 r7=0x2 accepted together;
  - -> pending_mask[7]=1 for 2 cycles; writes 0x1 then 0x2; r7 reads 0x2 afterwards.
- Register 0 drop:
  - req1 r0=0xDEAD;
  - -> handshake completes, rf_write stays 0, pending_mask stays 0.
- Sustained contention fairness:
  - both requesters valid every cycle for 20 cycles;
  - -> grants strictly alternate 01/10, and each requester gets 10 writes.
